// File: rtl/apb_pkg.sv
// Shared types for the multi-slave APB master: FSM state encoding and the
// queued request record.
package apb_pkg;

  // Widest address/data the request record carries; instances use the low bits.
  localparam int APB_ADDR_MAX = 32;
  localparam int APB_DATA_MAX = 64;
  localparam int APB_STRB_MAX = APB_DATA_MAX / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                    write;
    logic [APB_ADDR_MAX-1:0] addr;
    logic [APB_DATA_MAX-1:0] wdata;
    logic [APB_STRB_MAX-1:0] strb;
  } apb_req_t;

endpackage

// File: rtl/apb_req_fifo.sv
// First-word-fall-through request queue; rdata shows the head whenever
// empty is low.
module apb_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_master_mp.sv
// Queued APB master driving NSLV slaves; slave select is decoded from the
// top address bits, with a per-transfer pready timeout.
module apb_master_mp
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic [NSLV-1:0]     psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = $clog2(NSLV);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;

  apb_state_t state;
  apb_state_t state_next;
  apb_req_t   cur;
  apb_req_t   head;

  logic [REQ_W-1:0]  fifo_wdata;
  logic [REQ_W-1:0]  fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] wdata_masked;
  logic [STRB_W-1:0] strb_masked;
  logic [7:0]        wait_cnt;
  logic              wait_hit;
  logic              access_done;
  logic [SEL_W-1:0]  slv_idx;
  logic              unused_cur;

  // Reads carry no write payload, so it is dropped before queueing.
  assign wdata_masked = req_write ? req_wdata : '0;
  assign strb_masked  = req_write ? req_strb  : '0;
  assign fifo_wdata   = {req_write, req_addr, wdata_masked, strb_masked};

  assign req_ready = !fifo_full && !preset;
  assign fifo_push = req_valid && req_ready;
  assign fifo_pop  = (state_next == SETUP);

  apb_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (pclk),
    .rst   (preset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    head       = '0;
    head.write = fifo_rdata[REQ_W-1];
    head.addr  = APB_ADDR_MAX'(fifo_rdata[STRB_W+DATA_W +: ADDR_W]);
    head.wdata = APB_DATA_MAX'(fifo_rdata[STRB_W +: DATA_W]);
    head.strb  = APB_STRB_MAX'(fifo_rdata[STRB_W-1:0]);
  end

  // Timeout fires on the ACCESS cycle that would push the count to TIMEOUT.
  assign wait_hit    = !pready && (wait_cnt == 8'(TIMEOUT - 1));
  assign access_done = (state == ACCESS) && (pready || wait_hit);

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (access_done) state_next = fifo_empty ? IDLE : SETUP;
      default: state_next = IDLE;
    endcase
  end

  assign slv_idx = cur.addr[ADDR_W-1 -: SEL_W];

  always_comb begin
    psel    = '0;
    penable = 1'b0;
    if (state != IDLE)  psel[slv_idx] = 1'b1;
    if (state == ACCESS) penable      = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cur         <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (fifo_pop) cur <= head;
      if (state == SETUP)                  wait_cnt <= '0;
      else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + 1'b1;
      rsp_valid   <= access_done;
      rsp_err     <= access_done && (!pready || pslverr);
      rsp_timeout <= access_done && !pready;
      rsp_rdata   <= (access_done && pready && !cur.write) ? prdata : '0;
    end
  end

  assign pwrite = cur.write;
  assign paddr  = cur.addr[ADDR_W-1:0];
  assign pwdata = cur.wdata[DATA_W-1:0];
  assign pstrb  = cur.strb[STRB_W-1:0];

  // The record is sized for the widest instance; the spare high bits are
  // constant zero and intentionally left unread.
  assign unused_cur = ^cur;

endmodule

// File: tb/tb_apb_master_mp.sv
// Directed bench for apb_master_mp: a table of single transfers plus
// hand-written back-to-back, queue-full and reset-abort sequences.
module tb_apb_master_mp;

  logic        pclk;
  logic        preset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int n_checks = 0;
  int n_err    = 0;

  apb_master_mp dut (
    .pclk        (pclk),
    .preset      (preset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;     // pready-low ACCESS cycles before pready=1
    logic        slverr;
    logic [31:0] prdata;
    logic [3:0]  exp_psel;
    logic [31:0] exp_pwdata;
    logic [3:0]  exp_pstrb;
    int          exp_access;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs [6];

  logic [7:0]  b2b_addr [4];
  logic [31:0] b2b_data [4];
  logic [3:0]  b2b_psel [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " psel"},        psel,        0);
    check({tag, " penable"},     penable,     0);
    check({tag, " pwrite"},      pwrite,      0);
    check({tag, " paddr"},       paddr,       0);
    check({tag, " pwdata"},      pwdata,      0);
    check({tag, " pstrb"},       pstrb,       0);
    check({tag, " rsp_valid"},   rsp_valid,   0);
    check({tag, " rsp_rdata"},   rsp_rdata,   0);
    check({tag, " rsp_err"},     rsp_err,     0);
    check({tag, " rsp_timeout"}, rsp_timeout, 0);
    check({tag, " req_ready"},   req_ready,   0);
  endtask

  task automatic offer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] st);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_strb  = st;
  endtask

  task automatic wait_access(input string name);
    int n = 0;
    while (!penable && n < 10) begin
      @(negedge pclk);
      n++;
    end
    check(name, penable, 1);
  endtask

  // One request through an idle master, with the slave stalling v.waits cycles.
  task automatic run_vec(input vec_t v, input int idx);
    int  n_setup  = 0;
    int  n_access = 0;
    bit  done     = 0;
    string t = $sformatf("v%0d", idx);
    @(negedge pclk);
    check({t, " req_ready"}, req_ready, 1);
    offer(v.write, v.addr, v.wdata, v.strb);
    @(negedge pclk);
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (rsp_valid) begin
        done = 1;
        check({t, " setup cycles"},  n_setup,     1);
        check({t, " access cycles"}, n_access,    v.exp_access);
        check({t, " rsp_err"},       rsp_err,     v.exp_err);
        check({t, " rsp_timeout"},   rsp_timeout, v.exp_to);
        check({t, " rsp_rdata"},     rsp_rdata,   v.exp_rdata);
      end else begin
        check({t, " rsp quiet"}, {rsp_err, rsp_timeout, rsp_rdata}, 0);
        if (penable) begin
          n_access++;
          check({t, " access psel"},  psel,  v.exp_psel);
          check({t, " access paddr"}, paddr, v.addr);
          pready  = (n_access > v.waits);
          pslverr = pready ? v.slverr : 1'b0;
          prdata  = v.prdata;
        end else begin
          if (psel != 0) begin
            n_setup++;
            check({t, " setup psel"},   psel,   v.exp_psel);
            check({t, " setup paddr"},  paddr,  v.addr);
            check({t, " setup pwrite"}, pwrite, v.write);
            check({t, " setup pwdata"}, pwdata, v.exp_pwdata);
            check({t, " setup pstrb"},  pstrb,  v.exp_pstrb);
          end
          pready  = 1'b0;
          pslverr = 1'b0;
        end
        @(negedge pclk);
      end
    end
    if (!done) check({t, " rsp_valid seen"}, 0, 1);
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    @(negedge pclk);
    check({t, " pulse ended"}, {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    check({t, " back to idle"}, {psel, penable}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            wr    addr   wdata         strb  wt   err   prdata        psel     pwdata        pstrb acc exp_rdata     err   to
    vecs[0] = '{1'b1, 8'h45, 32'hDEADBEEF, 4'hF, 0,   1'b0, 32'h00000000, 4'b0010, 32'hDEADBEEF, 4'hF, 1,  32'h00000000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hC2, 32'hFFFFFFFF, 4'hF, 3,   1'b0, 32'h12345678, 4'b1000, 32'h00000000, 4'h0, 4,  32'h12345678, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h10, 32'h00000000, 4'h0, 0,   1'b1, 32'hA5A5A5A5, 4'b0001, 32'h00000000, 4'h0, 1,  32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h85, 32'h0BADF00D, 4'h3, 1,   1'b0, 32'hCAFEF00D, 4'b0100, 32'h0BADF00D, 4'h3, 2,  32'h00000000, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h7F, 32'h00000000, 4'h0, 255, 1'b0, 32'hFFFFFFFF, 4'b0010, 32'h00000000, 4'h0, 15, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'hE0, 32'h13579BDF, 4'hC, 2,   1'b1, 32'h00000000, 4'b1000, 32'h13579BDF, 4'hC, 3,  32'h00000000, 1'b1, 1'b0};

    b2b_addr[0] = 8'h01; b2b_data[0] = 32'h11111111; b2b_psel[0] = 4'b0001;
    b2b_addr[1] = 8'h42; b2b_data[1] = 32'h22222222; b2b_psel[1] = 4'b0010;
    b2b_addr[2] = 8'h83; b2b_data[2] = 32'h33333333; b2b_psel[2] = 4'b0100;
    b2b_addr[3] = 8'hC4; b2b_data[3] = 32'h44444444; b2b_psel[3] = 4'b1000;

    preset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    repeat (2) @(negedge pclk);
    check_reset_outputs("por");
    preset = 1'b0;
    @(negedge pclk);
    check("por released req_ready", req_ready, 1);
    check("por idle", {psel, penable}, 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Queue fill behind a stalled read, then drain back-to-back.
    @(negedge pclk);
    offer(1'b0, 8'h20, 32'h0, 4'h0);
    @(negedge pclk);
    req_valid = 1'b0;
    wait_access("b2b first access");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b push%0d ready", i), req_ready, 1);
      offer(1'b1, b2b_addr[i], b2b_data[i], 4'hF);
      @(negedge pclk);
    end
    check("b2b full ready", req_ready, 0);
    offer(1'b1, 8'hFF, 32'hBAD0BAD0, 4'hF);
    @(negedge pclk);
    check("b2b full still refused", req_ready, 0);
    req_valid = 1'b0;
    check("b2b still stalled", penable, 1);
    pready = 1'b1;
    prdata = 32'h55AA55AA;
    @(negedge pclk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b w%0d setup", i),  {psel, penable}, {b2b_psel[i], 1'b0});
      check($sformatf("b2b w%0d paddr", i),  paddr,  b2b_addr[i]);
      check($sformatf("b2b w%0d pwdata", i), pwdata, b2b_data[i]);
      check($sformatf("b2b rsp%0d valid", i), rsp_valid, 1);
      check($sformatf("b2b rsp%0d rdata", i), rsp_rdata, (i == 0) ? 32'h55AA55AA : 32'h0);
      @(negedge pclk);
      check($sformatf("b2b w%0d access", i), {psel, penable}, {b2b_psel[i], 1'b1});
      check($sformatf("b2b w%0d no rsp", i), rsp_valid, 0);
      @(negedge pclk);
    end
    check("b2b last idle", {psel, penable}, 0);
    check("b2b last rsp", {rsp_valid, rsp_err}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check($sformatf("b2b refused not issued %0d", i), {psel, rsp_valid}, 0);
    end
    pready = 1'b0;
    prdata = '0;

    // Reset during ACCESS with two requests queued.
    @(negedge pclk);
    offer(1'b0, 8'h30, 32'h0, 4'h0);
    @(negedge pclk);
    req_valid = 1'b0;
    wait_access("rst first access");
    offer(1'b1, 8'h50, 32'hAAAA0000, 4'hF);
    @(negedge pclk);
    offer(1'b1, 8'h60, 32'hBBBB0000, 4'hF);
    @(negedge pclk);
    req_valid = 1'b0;
    check("rst mid access", penable, 1);
    preset = 1'b1;
    @(negedge pclk);
    check_reset_outputs("mid");
    preset = 1'b0;
    pready = 1'b1;
    @(negedge pclk);
    check("mid released req_ready", req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mid stays idle %0d", i), {psel, penable, rsp_valid}, 0);
      @(negedge pclk);
    end
    pready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
